demux4_dispatch: RTL and testbench
==================================

# demux4_dispatch

Registered 1-to-4 dispatcher with a valid/ready handshake on every side; the counterpart of the 4:1 operation-result mux. It takes one operand word tagged with a 2-bit select (OP) and delivers it to one of four downstream channels (00→ch0, 01→ch1, 10→ch2, 11→ch3). Each channel has a one-entry holding register, so back-pressure on one unit does not block traffic to the others. It sits between the calculator front end and the four operation units.

## Interface
Parameters:
- WIDTH, 16, data word width

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream word present
- in_ready  output  1  dispatcher accepts the word this cycle
- in_data  input  WIDTH  word to dispatch
- in_sel  input  2  destination channel (OP)
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: channel k consumer takes the word
- out_d0, out_d1, out_d2, out_d3  output  WIDTH each  holding-register contents of channels 0..3
- stat_count  output  32  four 8-bit per-channel delivered-word counters, ch0 in [7:0], ch3 in [31:24]

## Operation
- Per-channel state is a 1-bit slot flag: EMPTY or FULL.
  - EMPTY→FULL on accept to that channel.
  - FULL→EMPTY on drain (out_valid[k] & out_ready[k]) with no accept to k in the same cycle.
  - FULL→FULL on drain plus accept in the same cycle. The register reloads with the new word and out_valid[k] stays high.
- in_ready = ~full[in_sel] | out_ready[in_sel]. This is a combinational path from out_ready to in_ready, with no path from in_valid.
- Accept = in_valid & in_ready. Only channel in_sel is written. The other channels are unaffected.
- out_valid[k] = full[k], driven directly from the flag register.
- out_dk changes only on accept to channel k. While out_valid[k] & ~out_ready[k], out_dk and out_valid[k] are held stable.
- When a channel is empty, its out_dk keeps the last word written to it; after reset it reads 0.
- Drains on different channels are independent. Any subset of the four can complete in the same cycle as one accept.
- Words accepted for the same channel are delivered in acceptance order. No reordering within a channel.

## Timing
- Latency: a word accepted at edge N is visible on out_dk with out_valid[k]=1 after edge N.
- Throughput: one word per cycle into one channel when its consumer holds out_ready high. No bubbles.
- Reset (synchronous, at the edge with rst=1):
  - all flags EMPTY, out_valid=4'b0000, out_d0..out_d3=0, stat_count=0.
  - in_ready reads 1 after reset.
- Reset mid-operation: held words are discarded without handshake. An accept in the reset cycle is ignored.
- in_ready is valid in every cycle, including while rst=1. The reset value dominates.

## Configuration
- DEMUX4_DISPATCH_STATS_EN defined:
  - counter k increments on each drain of channel k.
  - counters saturate at 8'hFF and never wrap.
  - counters are cleared by rst.
- Not defined: stat_count is tied to 32'h0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Basic routing: after reset, send 16'hA001/sel=0, 16'hA002/sel=1, 16'hA003/sel=2, 16'hA004/sel=3 with out_ready=4'hF → each word appears on out_d0..out_d3 respectively, one cycle after its accept, and no other channel's out_valid rises.
- Back-pressure isolation: hold out_ready[2]=0 and send 16'h1111/sel=2, then 16'h2222/sel=2 and 16'h3333/sel=0 → 16'h1111 is accepted; in_ready=0 while 16'h2222 is offered; send 16'h3333 with sel=0 → it is accepted and delivered on ch0. Then raise out_ready[2] → out_d2 stays 16'h1111 until the drain, and 16'h2222 is accepted in the same cycle.
- Simultaneous drain and accept: ch1 full with 16'h00AA, out_ready[1]=1, in_valid with 16'h00BB/sel=1 → out_valid[1] stays 1 and out_d1=16'h00BB on the next cycle.
- Streaming: 10 consecutive words 16'h0000..16'h0009 to sel=3 with out_ready[3]=1 → in_ready stays 1 throughout and out_d3 shows all 10 words in order. With DEMUX4_DISPATCH_STATS_EN defined, stat_count[31:24]=10.
- Reset mid-operation: all four channels full, assert rst for one cycle → out_valid=4'b0000, all out_dk=0, stat_count=0, in_ready=1.
- Counter saturation (DEMUX4_DISPATCH_STATS_EN defined): 300 drains on ch0 → stat_count[7:0]=8'hFF. Without the macro → stat_count=0 throughout.

Source files
------------

// File: rtl/demux4_dispatch_if.sv
// Handshake bundle for demux4_dispatch: one upstream valid/ready port and four
// downstream channels, plus the per-channel delivery counters.
interface demux4_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_d0;
    logic [WIDTH-1:0] out_d1;
    logic [WIDTH-1:0] out_d2;
    logic [WIDTH-1:0] out_d3;
    logic [31:0]      stat_count;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, stat_count
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_d0, out_d1, out_d2, out_d3, stat_count
    );
endinterface

// File: rtl/demux4_dispatch.sv
// Registered 1-to-4 dispatcher: one-entry holding slot per channel so a stalled
// unit never blocks the others. DEMUX4_DISPATCH_STATS_EN adds saturating drain counters.
module demux4_dispatch_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic             drn,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;

    slot_e st, st_nxt;

    always_ff @(posedge clk) begin
        if (rst) st <= EMPTY;
        else     st <= st_nxt;
    end

    // A drain and an accept in the same cycle keeps the slot occupied.
    always_comb begin
        st_nxt = st;
        case (st)
            EMPTY:   if (acc) st_nxt = FULL;
            FULL:    if (drn && !acc) st_nxt = EMPTY;
            default: st_nxt = EMPTY;
        endcase
    end

    always_comb begin
        full = (st == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst)      dout <= '0;
        else if (acc) dout <= din;
    end
endmodule

module demux4_dispatch #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    demux4_dispatch_if.slave bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            full;
    logic [NUM_LANES-1:0]            acc;
    logic [NUM_LANES-1:0]            drn;
    logic [NUM_LANES-1:0][WIDTH-1:0] dq;
    logic                            rdy;

    // Ready during reset regardless of stale flags; the accept itself is masked.
    assign rdy          = rst | ~full[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign bus.in_ready = rdy;
    assign bus.out_valid = full;
    assign drn          = full & bus.out_ready;

    assign bus.out_d0 = dq[0];
    assign bus.out_d1 = dq[1];
    assign bus.out_d2 = dq[2];
    assign bus.out_d3 = dq[3];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign acc[k] = bus.in_valid & rdy & ~rst & (bus.in_sel == 2'(k));

        demux4_dispatch_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .acc  (acc[k]),
            .drn  (drn[k]),
            .din  (bus.in_data),
            .full (full[k]),
            .dout (dq[k])
        );
    end

`ifdef DEMUX4_DISPATCH_STATS_EN
    logic [NUM_LANES-1:0][7:0] cnt;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)                          cnt[k] <= '0;
            else if (drn[k] && cnt[k] != 8'hFF) cnt[k] <= cnt[k] + 8'd1;
        end
    end

    assign bus.stat_count = cnt;
`else
    assign bus.stat_count = 32'h0;
`endif
endmodule

// File: tb/tb_demux4_dispatch.sv
// Randomized and directed bench for demux4_dispatch against a per-channel
// scoreboard model (queues of accepted words, drain counts).
module tb_demux4_dispatch;
    logic clk = 1'b0;
    logic rst;

    demux4_dispatch_if #(.WIDTH(16)) bus ();

    demux4_dispatch #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-channel queue of pending words, last written word, drain count.
    logic [15:0] sb [4][$];
    logic [15:0] mdl_d [4];
    int          mdl_cnt [4];
    bit          mknown = 1'b0;
    logic        last_rdy;

    logic [3:0][15:0] od;
    assign od = {bus.out_d3, bus.out_d2, bus.out_d1, bus.out_d0};

    function automatic logic [31:0] exp_stat();
        logic [31:0] s;
        s = 32'h0;
`ifdef DEMUX4_DISPATCH_STATS_EN
        for (int k = 0; k < 4; k++) s[k*8 +: 8] = (mdl_cnt[k] > 255) ? 8'hFF : mdl_cnt[k][7:0];
`endif
        return s;
    endfunction

    // One clock cycle: drive, check against model before the edge, advance model.
    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic [1:0] s, input logic [3:0] ordy);
        bit               exp_rdy;
        bit               accept;
        bit [3:0]         drain;
        logic [3:0]       ev;
        logic [3:0][15:0] sampled;
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        #1;
        exp_rdy  = r || !mknown || (sb[s].size() == 0) || ordy[s];
        last_rdy = bus.in_ready;
        checks++;
        if (r || mknown) begin
            if (bus.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b (sel=%0d)", bus.in_ready, exp_rdy, s);
            end
        end
        if (mknown) begin
            for (int k = 0; k < 4; k++) ev[k] = (sb[k].size() != 0);
            checks++;
            if (bus.out_valid !== ev) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b", bus.out_valid, ev);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (od[k] !== mdl_d[k]) begin
                    errors++;
                    $display("FAIL out_d%0d: got %h expected %h", k, od[k], mdl_d[k]);
                end
            end
            checks++;
            if (bus.stat_count !== exp_stat()) begin
                errors++;
                $display("FAIL stat_count: got %h expected %h", bus.stat_count, exp_stat());
            end
        end
        sampled = od;
        accept  = v && exp_rdy && !r;
        for (int k = 0; k < 4; k++) drain[k] = (sb[k].size() != 0) && ordy[k];
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                sb[k].delete();
                mdl_d[k]   = 16'h0;
                mdl_cnt[k] = 0;
            end
            mknown = 1'b1;
        end else if (mknown) begin
            for (int k = 0; k < 4; k++) begin
                if (drain[k]) begin
                    checks++;
                    if (sampled[k] !== sb[k][0]) begin
                        errors++;
                        $display("FAIL order ch%0d: delivered %h expected %h", k, sampled[k], sb[k][0]);
                    end
                    void'(sb[k].pop_front());
                    mdl_cnt[k]++;
                end
            end
            if (accept) begin
                sb[s].push_back(d);
                mdl_d[s] = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] ordy);
        step(1'b0, 1'b0, 16'h0, 2'd0, ordy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 16'hDEAD, 2'd1, 4'h0);
        checks++;
        if (bus.out_valid !== 4'b0000 || od !== 64'h0 || bus.stat_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b d=%h stat=%h expected all zero",
                     bus.out_valid, od, bus.stat_count);
        end
        idle(4'h0);
    endtask

    task automatic test_routing();
        logic [15:0] w [4];
        w = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, w[k], 2'(k), 4'hF);
            checks++;
            if (bus.out_valid !== (4'b0001 << k) || od[k] !== w[k]) begin
                errors++;
                $display("FAIL routing ch%0d: valid=%b d=%h expected valid=%b d=%h",
                         k, bus.out_valid, od[k], 4'b0001 << k, w[k]);
            end
        end
        idle(4'hF);
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, 16'h1111, 2'd2, 4'b1011);
        step(1'b0, 1'b1, 16'h2222, 2'd2, 4'b1011);
        checks++;
        if (last_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: in_ready=%b expected 0", last_rdy);
        end
        step(1'b0, 1'b1, 16'h3333, 2'd0, 4'b1011);
        checks++;
        if (last_rdy !== 1'b1 || bus.out_d0 !== 16'h3333 || bus.out_d2 !== 16'h1111) begin
            errors++;
            $display("FAIL bp_other: rdy=%b d0=%h d2=%h expected 1 3333 1111",
                     last_rdy, bus.out_d0, bus.out_d2);
        end
        step(1'b0, 1'b1, 16'h2222, 2'd2, 4'b1111);
        checks++;
        if (last_rdy !== 1'b1 || bus.out_d2 !== 16'h2222 || bus.out_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: rdy=%b d2=%h v2=%b expected 1 2222 1",
                     last_rdy, bus.out_d2, bus.out_valid[2]);
        end
        idle(4'hF);
    endtask

    task automatic test_drain_accept();
        step(1'b0, 1'b1, 16'h00AA, 2'd1, 4'b0000);
        step(1'b0, 1'b1, 16'h00BB, 2'd1, 4'b0010);
        checks++;
        if (bus.out_valid[1] !== 1'b1 || bus.out_d1 !== 16'h00BB) begin
            errors++;
            $display("FAIL drain_accept: v1=%b d1=%h expected 1 00bb", bus.out_valid[1], bus.out_d1);
        end
        idle(4'hF);
    endtask

    task automatic test_stream();
        logic [7:0] want;
        step(1'b1, 1'b0, 16'h0, 2'd0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 16'(i), 2'd3, 4'b1000);
            checks++;
            if (last_rdy !== 1'b1 || bus.out_d3 !== 16'(i)) begin
                errors++;
                $display("FAIL stream word %0d: rdy=%b d3=%h", i, last_rdy, bus.out_d3);
            end
        end
        idle(4'b1000);
`ifdef DEMUX4_DISPATCH_STATS_EN
        want = 8'd10;
`else
        want = 8'd0;
`endif
        checks++;
        if (bus.stat_count[31:24] !== want) begin
            errors++;
            $display("FAIL stream_count: got %0d expected %0d", bus.stat_count[31:24], want);
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 16'hC000 | 16'(k), 2'(k), 4'h0);
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++;
            $display("FAIL midreset_fill: valid=%b expected 1111", bus.out_valid);
        end
        step(1'b1, 1'b1, 16'hBEEF, 2'd0, 4'h0);
        checks++;
        if (bus.out_valid !== 4'b0000 || od !== 64'h0 || bus.stat_count !== 32'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: valid=%b d=%h stat=%h rdy=%b expected 0 0 0 1",
                     bus.out_valid, od, bus.stat_count, bus.in_ready);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] want;
        step(1'b1, 1'b0, 16'h0, 2'd0, 4'h0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'($urandom), 2'd0, 4'b0001);
        idle(4'b0001);
`ifdef DEMUX4_DISPATCH_STATS_EN
        want = 8'hFF;
`else
        want = 8'h00;
`endif
        checks++;
        if (bus.stat_count[7:0] !== want || bus.stat_count[31:8] !== 24'h0) begin
            errors++;
            $display("FAIL saturation: stat=%h expected ch0=%h others 0", bus.stat_count, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++)
            step(($urandom_range(63) == 0), 1'($urandom), 16'($urandom),
                 2'($urandom), 4'($urandom));
        for (int i = 0; i < 2; i++) idle(4'hF);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_sel    = 2'd0;
        bus.out_ready = 4'h0;
        @(negedge clk);
        test_reset();
        test_routing();
        test_backpressure();
        test_drain_accept();
        test_stream();
        test_midreset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
